// File: rtl/raycast_pkg.sv
// Shared raycaster types and colours: buffer FSM state, record width and the RGB565 palette.
package raycast_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } buf_state_t;

  localparam int RECORD_W = 41;

  localparam logic [15:0] CEIL_COLOR  = 16'h4208;
  localparam logic [15:0] FLOOR_COLOR = 16'h2104;

  localparam logic [15:0] PALETTE [8] = '{
    16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
    16'hFFE0, 16'hF81F, 16'h07FF, 16'h8410
  };

  // Y-facing walls are drawn darker: each RGB565 channel is halved independently.
  function automatic logic [15:0] shade_rgb565(input logic [15:0] c);
    return {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]};
  endfunction

endpackage

// File: rtl/xilinx_simple_dual_port_ram.sv
// Two-bank simple dual-port RAM (one write port, one registered read port).
// Address MSB selects the bank; each bank holds COLS entries.
module xilinx_simple_dual_port_ram #(
  parameter int DATA_W = 41,
  parameter int COLS   = 320,
  parameter int COL_W  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [COL_W:0]    wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [COL_W:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 * COLS;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Banks are packed back to back so non-power-of-two widths need no padding.
  function automatic logic [IDX_W-1:0] to_index(input logic [COL_W:0] a);
    return IDX_W'(a[COL_W-1:0]) + (a[COL_W] ? IDX_W'(COLS) : '0);
  endfunction

  always_ff @(posedge clk) begin
    if (we) begin
      mem[to_index(wr_addr)] <= wr_data;
    end
    rd_data <= mem[to_index(rd_addr)];
  end

endmodule

// File: rtl/column_buffer.sv
// Double-buffered per-column ray results: the ray engine fills the back bank in any
// order while the display reads the front bank through a 3-stage colour pipeline.
module column_buffer
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [8:0]  hcount_ray_in,
  input  logic [15:0] lineHeight_in,
  input  logic        wallType_in,
  input  logic [7:0]  mapData_in,
  input  logic [15:0] wallX_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [8:0]  hcount_in,
  input  logic [7:0]  vcount_in,
  input  logic        frame_swap_in,
  output logic [15:0] pixel_out,
  output logic [15:0] wallX_out,
  output logic [8:0]  hcount_out,
  output logic [7:0]  vcount_out,
  output logic        pixel_valid_out
);

  localparam int COL_W = 9;
  localparam int CNT_W = $clog2(SCREEN_WIDTH + 1);
  localparam logic [8:0]         COL_LIMIT = 9'(SCREEN_WIDTH);
  localparam logic [7:0]         ROW_LIMIT = 8'(SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(SCREEN_WIDTH);
  localparam logic signed [17:0] HALF_H    = 18'(SCREEN_HEIGHT / 2);
  localparam logic signed [17:0] MAX_ROW   = 18'(SCREEN_HEIGHT - 1);

  buf_state_t              state;
  logic                    front_bank;
  logic                    front_valid;
  logic [SCREEN_WIDTH-1:0] written;
  logic [CNT_W-1:0]        count;
  logic                    wr_en;

  assign wr_en = valid_in && ready_out && (hcount_ray_in < COL_LIMIT);

  // Bank-swap FSM; the written bitmap makes out-of-order and repeated columns safe.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state       <= FILL;
      ready_out   <= 1'b1;
      front_bank  <= 1'b0;
      front_valid <= 1'b0;
      written     <= '0;
      count       <= '0;
    end else begin
      if (wr_en && !written[hcount_ray_in]) begin
        written[hcount_ray_in] <= 1'b1;
        count                  <= count + 1'b1;
      end
      case (state)
        FILL: begin
          if (count == FULL_CNT) begin
            state     <= FULL;
            ready_out <= 1'b0;
          end
        end
        FULL: begin
          if (frame_swap_in) begin
            state       <= FILL;
            ready_out   <= 1'b1;
            front_bank  <= ~front_bank;
            front_valid <= 1'b1;
            written     <= '0;
            count       <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  logic [COL_W:0]          rd_addr;
  logic [RECORD_W-1:0]     rd_data;
  logic                    s1_valid, s2_valid;
  logic [8:0]              s1_h, s2_h;
  logic [7:0]              s1_v, s2_v;

  xilinx_simple_dual_port_ram #(
    .DATA_W (RECORD_W),
    .COLS   (SCREEN_WIDTH),
    .COL_W  (COL_W)
  ) u_ram (
    .clk     (pixel_clk_in),
    .we      (wr_en),
    .wr_addr ({~front_bank, hcount_ray_in}),
    .wr_data ({lineHeight_in, wallType_in, mapData_in, wallX_in}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Out-of-range positions read column 0 so the RAM is never indexed past a bank.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      rd_addr  <= '0;
      s1_h     <= '0;
      s1_v     <= '0;
      s2_h     <= '0;
      s2_v     <= '0;
    end else begin
      s1_valid <= front_valid && (hcount_in < COL_LIMIT) && (vcount_in < ROW_LIMIT);
      rd_addr  <= {front_bank, (hcount_in < COL_LIMIT) ? hcount_in : 9'd0};
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
      s2_valid <= s1_valid;
      s2_h     <= s1_h;
      s2_v     <= s1_v;
    end
  end

  logic signed [17:0] half_len, draw_start, draw_end, row;
  logic [15:0]        pixel_next, wallx_next;
  logic               unused_record_bits;

  assign unused_record_bits = ^{rd_data[25], rd_data[23:19]};

  // Widened signed arithmetic keeps huge line heights from wrapping the wall span.
  always_comb begin
    half_len   = $signed({3'b000, rd_data[40:26]});
    draw_start = HALF_H - half_len;
    if (draw_start < 0) draw_start = '0;
    draw_end   = HALF_H + half_len;
    if (draw_end > MAX_ROW) draw_end = MAX_ROW;
    row        = $signed({10'b0, s2_v});
    pixel_next = '0;
    wallx_next = '0;
    if (s2_valid) begin
      if (row < draw_start) begin
        pixel_next = CEIL_COLOR;
      end else if (row > draw_end) begin
        pixel_next = FLOOR_COLOR;
      end else begin
        pixel_next = rd_data[24] ? shade_rgb565(PALETTE[rd_data[18:16]])
                                 : PALETTE[rd_data[18:16]];
        wallx_next = rd_data[15:0];
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pixel_out       <= '0;
      wallX_out       <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      pixel_out       <= pixel_next;
      wallX_out       <= wallx_next;
      hcount_out      <= s2_h;
      vcount_out      <= s2_v;
      pixel_valid_out <= s2_valid;
    end
  end

endmodule

// File: tb/tb_column_buffer.sv
// Self-checking bench for column_buffer: random column records against a bank-level
// reference model, with directed frame-swap, ordering and reset scenarios.
module tb_column_buffer;

  localparam int W = 320;
  localparam int H = 240;

  localparam logic [15:0] CEIL  = 16'h4208;
  localparam logic [15:0] FLOOR = 16'h2104;
  logic [15:0] pal [8] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F,
                           16'hFFE0, 16'hF81F, 16'h07FF, 16'h8410};

  logic        pixel_clk_in = 1'b0;
  logic        rst_in;
  logic [8:0]  hcount_ray_in;
  logic [15:0] lineHeight_in;
  logic        wallType_in;
  logic [7:0]  mapData_in;
  logic [15:0] wallX_in;
  logic        valid_in;
  logic        ready_out;
  logic [8:0]  hcount_in;
  logic [7:0]  vcount_in;
  logic        frame_swap_in;
  logic [15:0] pixel_out;
  logic [15:0] wallX_out;
  logic [8:0]  hcount_out;
  logic [7:0]  vcount_out;
  logic        pixel_valid_out;

  column_buffer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_in          (rst_in),
    .hcount_ray_in   (hcount_ray_in),
    .lineHeight_in   (lineHeight_in),
    .wallType_in     (wallType_in),
    .mapData_in      (mapData_in),
    .wallX_in        (wallX_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .frame_swap_in   (frame_swap_in),
    .pixel_out       (pixel_out),
    .wallX_out       (wallX_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .pixel_valid_out (pixel_valid_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: the two banks as plain arrays plus a set of written columns.
  logic [40:0] m_back  [W];
  logic [40:0] m_front [W];
  bit          m_written [W];
  int          m_count;
  bit          m_full;
  bit          m_front_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit accept, swap, next_full;
    logic [40:0] tmp;
    accept    = valid_in && !m_full && (hcount_ray_in < W);
    swap      = frame_swap_in && m_full;
    next_full = m_full ? !swap : (m_count == W);
    if (accept) begin
      m_back[hcount_ray_in] = {lineHeight_in, wallType_in, mapData_in, wallX_in};
      if (!m_written[hcount_ray_in]) begin
        m_written[hcount_ray_in] = 1'b1;
        m_count++;
      end
    end
    if (swap) begin
      for (int i = 0; i < W; i++) begin
        tmp          = m_front[i];
        m_front[i]   = m_back[i];
        m_back[i]    = tmp;
        m_written[i] = 1'b0;
      end
      m_count       = 0;
      m_front_valid = 1'b1;
    end
    m_full = next_full;
    @(posedge pixel_clk_in);
    #1;
  endtask

  function automatic logic [40:0] rand_rec();
    logic [15:0] lh;
    lh = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
    return {lh, 1'($urandom), 8'($urandom), 16'($urandom)};
  endfunction

  task automatic apply_stimulus(input int col, input logic [40:0] rec);
    valid_in      = 1'b1;
    hcount_ray_in = 9'(col);
    {lineHeight_in, wallType_in, mapData_in, wallX_in} = rec;
    cycle();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in        = 1'b1;
    valid_in      = 1'b0;
    frame_swap_in = 1'b0;
    @(posedge pixel_clk_in); #1;
    @(posedge pixel_clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < W; i++) m_written[i] = 1'b0;
    m_count       = 0;
    m_full        = 1'b0;
    m_front_valid = 1'b0;
  endtask

  task automatic do_swap();
    frame_swap_in = 1'b1;
    cycle();
    frame_swap_in = 1'b0;
  endtask

  // Expected display from the front bank, straight from the wall-span rules.
  task automatic expect_pixel(input int h, input int v, output logic [15:0] pix,
                              output logic [15:0] wx, output logic vld);
    logic [40:0] rec;
    int lh, top, bot, c, r, g, b;
    pix = '0; wx = '0; vld = 1'b0;
    if (m_front_valid && h < W && v < H) begin
      vld = 1'b1;
      rec = m_front[h];
      lh  = int'(rec[40:25]);
      top = H / 2 - lh / 2;
      if (top < 0) top = 0;
      bot = H / 2 + lh / 2;
      if (bot > H - 1) bot = H - 1;
      if (v < top) pix = CEIL;
      else if (v > bot) pix = FLOOR;
      else begin
        c = int'(pal[int'(rec[23:16]) % 8]);
        if (rec[24]) begin
          r = c / 2048; g = (c / 32) % 64; b = c % 32;
          c = (r / 2) * 2048 + (g / 2) * 32 + (b / 2);
        end
        pix = 16'(c);
        wx  = rec[15:0];
      end
    end
  endtask

  task automatic check_output(input int h, input int v);
    logic [15:0] e_pix, e_wx;
    logic        e_vld;
    expect_pixel(h, v, e_pix, e_wx, e_vld);
    hcount_in = 9'(h);
    vcount_in = 8'(v);
    cycle(); cycle(); cycle();
    check($sformatf("pix(%0d,%0d)", h, v), 64'(pixel_out), 64'(e_pix));
    check($sformatf("wallx(%0d,%0d)", h, v), 64'(wallX_out), 64'(e_wx));
    check($sformatf("valid_pos(%0d,%0d)", h, v),
          64'({pixel_valid_out, hcount_out, vcount_out}), 64'({e_vld, 9'(h), 8'(v)}));
  endtask

  task automatic check_random_pixels(input int n);
    for (int i = 0; i < n; i++) check_output($urandom_range(0, W - 1), $urandom_range(0, H - 1));
  endtask

  initial begin
    logic [40:0] rec;
    hcount_ray_in = '0; lineHeight_in = '0; wallType_in = 1'b0; mapData_in = '0;
    wallX_in = '0; hcount_in = '0; vcount_in = '0;
    for (int i = 0; i < W; i++) begin
      m_back[i] = '0; m_front[i] = '0;
    end
    do_reset();
    check("reset_ready", 64'(ready_out), 64'd1);
    check("reset_pixel_valid", 64'(pixel_valid_out), 64'd0);
    check("reset_pixel", 64'(pixel_out), 64'd0);

    $display("[TB] in-order fill with directed columns");
    for (int c = 0; c < W - 1; c++) begin
      rec = rand_rec();
      case (c)
        5:  rec = {16'd120, 1'b0, 8'd1, 16'($urandom)};
        7:  rec = {16'd80, 1'b1, 8'd2, 16'($urandom)};
        20: rec = {16'hFFFF, 1'b0, 8'd3, 16'($urandom)};
        21: rec = {16'd0, 1'b0, 8'd4, 16'($urandom)};
        default: ;
      endcase
      apply_stimulus(c, rec);
    end
    apply_stimulus(400, rand_rec());
    cycle(); cycle();
    check("ready_oob_dropped", 64'(ready_out), 64'd1);
    do_swap();
    cycle();
    check("ready_partial_swap", 64'(ready_out), 64'd1);
    check_output(5, 100);
    check_output(200, 30);

    apply_stimulus(W - 1, rand_rec());
    check("ready_after_last", 64'(ready_out), 64'd1);
    cycle();
    check("ready_full", 64'(ready_out), 64'd0);
    valid_in = 1'b1; hcount_ray_in = 9'd5; lineHeight_in = 16'd7; mapData_in = 8'd6;
    frame_swap_in = 1'b1;
    cycle();
    valid_in = 1'b0; frame_swap_in = 1'b0;
    check("ready_after_swap", 64'(ready_out), 64'd1);
    check_output(5, 59);  check_output(5, 60);  check_output(5, 120);
    check_output(5, 180); check_output(5, 181); check_output(7, 120);
    check_output(20, 0);  check_output(20, 239);
    check_output(21, 119); check_output(21, 120); check_output(21, 121);
    check_output(320, 100); check_output(10, 240);
    check_random_pixels(10);

    $display("[TB] reverse-order fill with duplicate column");
    for (int c = W - 1; c >= 0; c--) begin
      if (c == 0) check("rev_ready_before_last", 64'(ready_out), 64'd1);
      if (c == 10) begin
        apply_stimulus(10, {16'd50, 1'b0, 8'd3, 16'($urandom)});
        apply_stimulus(10, {16'd200, 1'b1, 8'd6, 16'($urandom)});
      end else begin
        apply_stimulus(c, rand_rec());
      end
    end
    cycle();
    check("rev_ready_full", 64'(ready_out), 64'd0);
    do_swap();
    check_output(10, 19); check_output(10, 20); check_output(10, 220); check_output(10, 221);
    check_random_pixels(10);

    $display("[TB] reset mid-fill then refill");
    for (int c = 0; c < 150; c++) apply_stimulus(c, rand_rec());
    do_reset();
    check("midfill_ready", 64'(ready_out), 64'd1);
    check("midfill_pixel_valid", 64'(pixel_valid_out), 64'd0);
    check_output(3, 100);
    for (int c = 0; c < W; c++) begin
      if (c == W - 1) check("refill_ready_before_last", 64'(ready_out), 64'd1);
      apply_stimulus(c, rand_rec());
    end
    cycle();
    check("refill_ready_full", 64'(ready_out), 64'd0);
    do_swap();
    check_random_pixels(12);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
